// File: rtl/pwm_capture_pkg.sv
// Shared PWM definitions: capture FSM state encoding and default counter sizing.
package pwm_capture_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MEASURE = 1'b1
    } state_t;

    localparam int DEF_CNT_W      = 10;
    localparam int DEF_MAX_PERIOD = 1023;

endpackage

// File: rtl/pwm_capture_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module pwm_capture_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture with timeout. Define PWM_CAPTURE_SYNC_EN to put a
// two-flop synchronizer in front of the edge detector (asynchronous i_pwm sources).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no rising edge seen since reset; counters held at zero
// ST_MEASURE | counting a period from the last rise (or timeout restart)
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int MAX_PERIOD = DEF_MAX_PERIOD
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pwm,
    output logic [CNT_W-1:0] o_high_count,
    output logic [CNT_W-1:0] o_period,
    output logic             o_valid,
    output logic             o_timeout,
    output logic             o_locked
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PERIOD);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    state_t           state, state_next;
    logic             s, s_prev, rise, at_max;
    logic [CNT_W-1:0] period_cnt, high_cnt, s_ext;

`ifdef PWM_CAPTURE_SYNC_EN
    pwm_capture_sync u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .d     (i_pwm),
        .q     (s)
    );
`else
    assign s = i_pwm;
`endif

    assign rise   = s & ~s_prev;
    assign at_max = (period_cnt == MAX_CNT);
    assign s_ext  = {{(CNT_W-1){1'b0}}, s};

    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (rise) state_next = ST_MEASURE;
            ST_MEASURE: state_next = ST_MEASURE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // period_cnt counts cycles since the window started, so a rise sees t1-t0 directly.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s_prev       <= 1'b0;
            period_cnt   <= '0;
            high_cnt     <= '0;
            o_period     <= '0;
            o_high_count <= '0;
            o_valid      <= 1'b0;
            o_timeout    <= 1'b0;
            o_locked     <= 1'b0;
        end else begin
            s_prev  <= s;
            o_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        period_cnt <= ONE;
                        high_cnt   <= ONE;
                        o_locked   <= 1'b1;
                    end else begin
                        period_cnt <= '0;
                        high_cnt   <= '0;
                    end
                end
                ST_MEASURE: begin
                    // A rise landing on the timeout cycle wins: it is a real period.
                    if (rise || at_max) begin
                        o_period     <= period_cnt;
                        o_high_count <= high_cnt;
                        o_timeout    <= ~rise;
                        o_valid      <= 1'b1;
                        period_cnt   <= ONE;
                        high_cnt     <= s_ext;
                    end else begin
                        period_cnt <= period_cnt + ONE;
                        high_cnt   <= high_cnt + s_ext;
                    end
                end
                default: begin
                    period_cnt <= '0;
                    high_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: table-driven waveforms plus timeout/reset sequences.
module tb_pwm_capture;

    localparam int CNT_W = 10;
    localparam int MAXP  = 1023;
`ifdef PWM_CAPTURE_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst;
    logic             i_pwm;
    logic [CNT_W-1:0] o_high_count;
    logic [CNT_W-1:0] o_period;
    logic             o_valid;
    logic             o_timeout;
    logic             o_locked;

    pwm_capture #(.CNT_W(CNT_W), .MAX_PERIOD(MAXP)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pwm        (i_pwm),
        .o_high_count (o_high_count),
        .o_period     (o_period),
        .o_valid      (o_valid),
        .o_timeout    (o_timeout),
        .o_locked     (o_locked)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int per;
        int hi;
        int to;
        int cyc;
    } exp_t;

    typedef struct {
        int per;
        int hi;
        int n;
        int exp_per;
        int exp_hi;
        int exp_to;
    } vec_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   drive_cyc = 0;
    int   last_rise = 0;
    bit   have_prev = 0;
    int   pend_per, pend_hi, pend_to;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int per, input int hi, input int to, input int at);
        exp_t e;
        e.per = per;
        e.hi  = hi;
        e.to  = to;
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic step(input logic b);
        @(posedge i_clk);
        #1;
        i_pwm     = b;
        drive_cyc = cyc;
    endtask

    // One PWM period starting with a rise; the rise closes the previously pending period.
    task automatic run_period(input int per, input int hi, input int eper, input int ehi,
                              input int eto);
        for (int i = 0; i < per; i++) begin
            step(i < hi);
            if (i == 0) begin
                last_rise = drive_cyc;
                if (have_prev) push(pend_per, pend_hi, pend_to, drive_cyc + LAT);
                have_prev = 1;
            end
        end
        pend_per = eper;
        pend_hi  = ehi;
        pend_to  = eto;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge i_clk);
        chk(name, sb.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"},   int'(o_valid),      0);
        chk({tag, "_period"},  int'(o_period),     0);
        chk({tag, "_high"},    int'(o_high_count), 0);
        chk({tag, "_timeout"}, int'(o_timeout),    0);
        chk({tag, "_locked"},  int'(o_locked),     0);
    endtask

    // Scoreboard consumer: every strobe must match the oldest pending expectation.
    always @(negedge i_clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("period",    int'(o_period),     e.per);
                chk("high",      int'(o_high_count), e.hi);
                chk("timeout",   int'(o_timeout),    e.to);
                chk("valid_cyc", cyc,                e.cyc);
                chk("high_le_period", int'(o_high_count <= o_period), 1);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish by 2ms");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    vec_t vecs[6];

    initial begin
        int r;
        vecs[0] = '{256,   64, 3, 256,   64, 0};
        vecs[1] = '{256,  128, 2, 256,  128, 0};
        vecs[2] = '{256,  255, 2, 256,  255, 0};
        vecs[3] = '{100,    1, 2, 100,    1, 0};
        vecs[4] = '{2,      1, 3, 2,      1, 0};
        vecs[5] = '{1023, 500, 2, 1023, 500, 0};

        i_rst = 1'b1;
        i_pwm = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check_zero("reset");
        @(posedge i_clk);
        #1 i_rst = 1'b0;

        // Line low from reset: never locks, never strobes.
        repeat (1100) step(1'b0);
        @(negedge i_clk);
        chk("low_locked", int'(o_locked), 0);

        // A single pulse locks without a strobe.
        step(1'b1);
        @(negedge i_clk);
        chk("lock_not_yet", int'(o_locked), 0);
        repeat (9) step(1'b1);
        repeat (100) step(1'b0);
        @(negedge i_clk);
        chk("locked_after_rise", int'(o_locked), 1);
        chk("no_valid_after_lock", sb.size(), 0);
        have_prev = 1;
        pend_per  = 110;
        pend_hi   = 10;
        pend_to   = 0;

        foreach (vecs[v])
            for (int k = 0; k < vecs[v].n; k++)
                run_period(vecs[v].per, vecs[v].hi, vecs[v].exp_per, vecs[v].exp_hi,
                           vecs[v].exp_to);

        // Constant high for 3000 cycles, then constant low.
        step(1'b1);
        r = drive_cyc;
        push(pend_per, pend_hi, pend_to, r + LAT);
        push(MAXP, MAXP, 1, r + LAT + MAXP);
        push(MAXP, MAXP, 1, r + LAT + 2 * MAXP);
        push(MAXP, 954,  1, r + LAT + 3 * MAXP);
        push(MAXP, 0,    1, r + LAT + 4 * MAXP);
        have_prev = 0;
        repeat (2999) step(1'b1);
        repeat (1100) step(1'b0);
        drain("drain_timeouts");

        // Reset to a clean state, run a wave, then reset 100 cycles into a period.
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        for (int k = 0; k < 3; k++) run_period(256, 32, 256, 32, 0);
        for (int i = 0; i < 100; i++) begin
            step(i < 32);
            if (i == 0) push(pend_per, pend_hi, pend_to, drive_cyc + LAT);
        end
        drain("drain_pre_reset");
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        i_pwm = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        check_zero("midreset");
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b0;
        have_prev = 0;
        repeat (20) step(1'b0);
        chk("no_stale_valid", sb.size(), 0);

        for (int k = 0; k < 3; k++) run_period(256, 32, 256, 32, 0);
        push(MAXP, 32, 1, last_rise + LAT + MAXP);
        repeat (1100) step(1'b0);
        drain("drain_final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
